// File: rtl/branch_predict_ctrl_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
package bp_pkg;

  typedef enum logic {FSM_IDLE, FSM_FLUSH} state_t;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [31:0] PC_INC = 32'd4;

  // Word-aligned PCs: the upper bits above the index form the tag.
  function automatic int tag_bits(input int idx_bits);
    return 30 - idx_bits;
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_if.sv
// IF-side prediction, EX-side resolution and redirect/flush bundle.
interface branch_predict_ctrl_if;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_jump;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] mispredict_cnt;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_is_jump, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, redirect_valid, redirect_pc, flush,
           mispredict_cnt
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_is_jump, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, redirect_valid, redirect_pc, flush,
           mispredict_cnt
  );
endinterface

// File: rtl/branch_predict_ctrl_table.sv
// Direct-mapped BHT (2-bit counters) + tagged BTB: async read, sync write.
module bp_table
  import bp_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int IDX_BITS = $clog2(ENTRIES),
  parameter int TAG_W    = tag_bits(IDX_BITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_valid,
  output logic                rd_jump,
  output logic [1:0]          rd_ctr,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [31:0]         rd_target,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_taken,
  input  logic                wr_jump,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [31:0]         wr_target
);

  logic [1:0]         ctr    [ENTRIES];
  logic [TAG_W-1:0]   tag    [ENTRIES];
  logic [31:0]        target [ENTRIES];
  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] jump;
  logic [1:0]         ctr_cur;
  logic [1:0]         ctr_nxt;

  assign rd_valid  = valid[rd_idx];
  assign rd_jump   = jump[rd_idx];
  assign rd_ctr    = ctr[rd_idx];
  assign rd_tag    = tag[rd_idx];
  assign rd_target = target[rd_idx];

  assign ctr_cur = ctr[wr_idx];

  always_comb begin
    ctr_nxt = ctr_cur;
    if (wr_jump)
      ctr_nxt = ST;
    else if (wr_taken)
      ctr_nxt = (ctr_cur == ST) ? ST : ctr_cur + 2'd1;
    else
      ctr_nxt = (ctr_cur == SNT) ? SNT : ctr_cur - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= WNT;
      valid <= '0;
    end else if (wr_en) begin
      ctr[wr_idx] <= ctr_nxt;
      if (wr_taken) valid[wr_idx] <= 1'b1;
    end
  end

  // Payload fields are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_en && wr_taken) begin
      tag[wr_idx]    <= wr_tag;
      target[wr_idx] <= wr_target;
      jump[wr_idx]   <= wr_jump;
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch predictor top: same-cycle prediction, mispredict detect, redirect/flush FSM.
module branch_predict_ctrl
  import bp_pkg::*;
#(
  parameter int ENTRIES      = 64,
  parameter int IDX_BITS     = $clog2(ENTRIES),
  parameter int FLUSH_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  branch_predict_ctrl_if.slave bus
);

  localparam int         TAG_W    = tag_bits(IDX_BITS);
  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        rv_q, rv_d;
  logic [31:0] rpc_q, rpc_d;
  logic [31:0] mcnt_q, mcnt_d;

  logic                rd_valid, rd_jump;
  logic [1:0]          rd_ctr;
  logic [TAG_W-1:0]    rd_tag;
  logic [31:0]         rd_target;
  logic                hit, upd_en, mispredict;

  bp_table #(.ENTRIES(ENTRIES), .IDX_BITS(IDX_BITS), .TAG_W(TAG_W)) u_table (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (bus.if_pc[IDX_BITS+1:2]),
    .rd_valid  (rd_valid),
    .rd_jump   (rd_jump),
    .rd_ctr    (rd_ctr),
    .rd_tag    (rd_tag),
    .rd_target (rd_target),
    .wr_en     (upd_en),
    .wr_idx    (bus.ex_pc[IDX_BITS+1:2]),
    .wr_taken  (bus.ex_taken),
    .wr_jump   (bus.ex_is_jump),
    .wr_tag    (bus.ex_pc[31:IDX_BITS+2]),
    .wr_target (bus.ex_target)
  );

  assign hit             = rd_valid && (rd_tag == bus.if_pc[31:IDX_BITS+2]);
  assign bus.pred_taken  = hit && (rd_jump || rd_ctr[1]);
  assign bus.pred_target = bus.pred_taken ? rd_target : bus.if_pc + PC_INC;

  // EX results arriving during recovery belong to squashed instructions.
  assign upd_en     = bus.ex_valid && (state_q == FSM_IDLE);
  assign mispredict = upd_en &&
                      ((bus.ex_taken != bus.ex_pred_taken) ||
                       (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rv_d    = 1'b0;
    rpc_d   = rpc_q;
    mcnt_d  = mcnt_q;
    case (state_q)
      FSM_IDLE: begin
        if (mispredict) begin
          state_d = FSM_FLUSH;
          cnt_d   = CNT_INIT;
          rv_d    = 1'b1;
          rpc_d   = bus.ex_taken ? bus.ex_target : bus.ex_pc + PC_INC;
          if (mcnt_q != '1) mcnt_d = mcnt_q + 32'd1;
        end
      end
      FSM_FLUSH: begin
        if (cnt_q == 3'd0) state_d = FSM_IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = FSM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FSM_IDLE;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
      mcnt_q  <= mcnt_d;
    end
  end

  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = rpc_q;
  assign bus.flush          = (state_q == FSM_FLUSH);
  assign bus.mispredict_cnt = mcnt_q;

endmodule
